// File: rtl/fsm_arb_pkg.sv
// -----------------------------------------------------------------------------
// fsm_arb_pkg
// Shared types for the FSM-unit job arbiter.
//   arb_state_t : arbiter state (IDLE, CLEAR, RUN, DONE)
//   FSM_OUT_W   : width of the FSM unit result
//   arb_rsp_t   : captured response {id, data, cycles, timeout}. Field widths
//                 are sized for the largest supported configuration
//                 (NUM_REQ <= 8, CNT_W <= 16); users truncate to their widths.
// -----------------------------------------------------------------------------
package fsm_arb_pkg;

   localparam int FSM_OUT_W    = 5;
   localparam int RSP_ID_W_MAX  = 3;
   localparam int RSP_CNT_W_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   typedef struct packed {
      logic [RSP_ID_W_MAX-1:0]  id;
      logic [FSM_OUT_W-1:0]     data;
      logic [RSP_CNT_W_MAX-1:0] cycles;
      logic                     timeout;
   } arb_rsp_t;

endpackage

// File: rtl/fsm_job_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: selects the first set request bit scanning
// upward from i_rr_ptr with wrap-around.
//   i_req    : request vector
//   i_rr_ptr : index to start scanning from
//   o_gnt    : one-hot grant (zero when no request)
//   o_id     : index of the granted request
//   o_any    : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_rr_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_id,
   output logic               o_any
);

   logic [ID_W-1:0] w_idx;

   always_comb begin
      o_gnt = '0;
      o_id  = '0;
      o_any = 1'b0;
      w_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Candidate index wraps back to 0 past the last requester.
         w_idx = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
         if (!o_any && i_req[w_idx]) begin
            o_any        = 1'b1;
            o_id         = w_idx;
            o_gnt[w_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fsm_job_arbiter.sv
// -----------------------------------------------------------------------------
// fsm_job_arbiter
// Shares one FSM unit between NUM_REQ requesters. Each job: grant round-robin,
// hold the unit in reset for one CLEAR cycle, run it with start held high until
// it reports ready (or times out), then emit a one-cycle tagged response.
//
// Optional feature (macro FSM_ARB_TIMEOUT_EN):
//   defined   : a job is aborted after TIMEOUT_CYCLES RUN cycles
//   undefined : RUN waits forever, rsp_timeout is 0, the cycle counter saturates
//
// Ports:
//   clk_p        rising-edge clock
//   reset        synchronous active-low reset
//   req          per-requester job request (level)
//   gnt          one-hot owner of the current job, zero when idle
//   fsm_reset    active-high reset to the FSM unit
//   fsm_start    start to the FSM unit
//   fsm_out      FSM unit result
//   fsm_ready    FSM unit done flag (level)
//   rsp_valid    one-cycle response strobe
//   rsp_id       index of the requester served
//   rsp_data     captured fsm_out
//   rsp_cycles   RUN cycles taken
//   rsp_timeout  job aborted by timeout
//   busy         high in every state except IDLE
//   o_dbg_state  current arbiter state (arb_state_t encoding)
//
// Handshake: req is a level that is sampled only in IDLE; a job, once granted,
// always runs to completion regardless of req. rsp_valid is a single-cycle
// strobe with no back-pressure; rsp_* stay stable until the next response.
// -----------------------------------------------------------------------------
module fsm_job_arbiter
   import fsm_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 200
) (
   input  logic                       clk_p,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       fsm_reset,
   output logic                       fsm_start,
   input  logic [FSM_OUT_W-1:0]       fsm_out,
   input  logic                       fsm_ready,
   output logic                       rsp_valid,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id,
   output logic [FSM_OUT_W-1:0]       rsp_data,
   output logic [CNT_W-1:0]           rsp_cycles,
   output logic                       rsp_timeout,
   output logic                       busy,
   output logic [1:0]                 o_dbg_state
);

   localparam int ID_W = $clog2(NUM_REQ);

   // Elaboration-time configuration guard.
   if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_W > RSP_CNT_W_MAX ||
       TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
      $error("fsm_job_arbiter: unsupported parameter combination");
   end

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    r_id;
   logic [NUM_REQ-1:0] r_gnt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_fsm_reset;
   logic               r_fsm_start;
   logic               r_rsp_valid;
   arb_rsp_t           r_rsp;

   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [ID_W-1:0]    w_pick_id;
   logic               w_pick_any;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_timeout_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .i_req    (req),
      .i_rr_ptr (r_rr_ptr),
      .o_gnt    (w_pick_gnt),
      .o_id     (w_pick_id),
      .o_any    (w_pick_any)
   );

`ifdef FSM_ARB_TIMEOUT_EN
   assign w_cnt_next    = r_cnt + CNT_W'(1);
   assign w_timeout_hit = (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));
`else
   // Without a timeout the counter can run long; saturate instead of wrapping.
   assign w_cnt_next    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_timeout_hit = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_any) w_state_nxt = CLEAR;
         CLEAR:   w_state_nxt = RUN;
         RUN:     if (fsm_ready || w_timeout_hit) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_p) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_id        <= '0;
         r_gnt       <= '0;
         r_cnt       <= '0;
         r_fsm_reset <= 1'b1;
         r_fsm_start <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         // Unit controls are registered from the next state so they line up
         // exactly with the state they belong to.
         r_fsm_reset <= (w_state_nxt == CLEAR);
         r_fsm_start <= (w_state_nxt == RUN);
         r_rsp_valid <= (w_state_nxt == DONE);
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_gnt    <= w_pick_gnt;
                  r_id     <= w_pick_id;
                  r_rr_ptr <= (w_pick_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                : w_pick_id + ID_W'(1);
               end
            end
            CLEAR: r_cnt <= '0;
            RUN: begin
               r_cnt <= w_cnt_next;
               // Ready takes priority over a coincident timeout.
               if (fsm_ready) begin
                  r_rsp.id      <= RSP_ID_W_MAX'(r_id);
                  r_rsp.data    <= fsm_out;
                  r_rsp.cycles  <= RSP_CNT_W_MAX'(w_cnt_next);
                  r_rsp.timeout <= 1'b0;
               end else if (w_timeout_hit) begin
                  r_rsp.id      <= RSP_ID_W_MAX'(r_id);
                  r_rsp.data    <= '0;
                  r_rsp.cycles  <= RSP_CNT_W_MAX'(TIMEOUT_CYCLES);
                  r_rsp.timeout <= 1'b1;
               end
            end
            DONE:    r_gnt <= '0;
            default: r_gnt <= '0;
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign fsm_reset   = r_fsm_reset;
   assign fsm_start   = r_fsm_start;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = ID_W'(r_rsp.id);
   assign rsp_data    = r_rsp.data;
   assign rsp_cycles  = CNT_W'(r_rsp.cycles);
   assign rsp_timeout = r_rsp.timeout;
   assign busy        = (r_state != IDLE);
   assign o_dbg_state = r_state;

endmodule
